window_buffer_kxk: RTL and testbench

Generic K×K sliding-window register array, parametrised in kernel size K, pixel width DW and frame geometry. It is the successor to the fixed 7×7 window buffer. It consumes one vertical column of K pixels per accepted beat from the upstream line buffers and shifts that column into a K×K window. It emits a window, with position tags, to the downstream filter/kernel datapath (median, Gaussian, morphology). It adds frame clear and column-position outputs, and optionally zero-padded left-border windows.

---
 rtl/window_buffer_pkg.sv | 18 +
 rtl/window_buffer_kxk_controller.sv | 104 ++++++++++
 rtl/window_buffer_kxk.sv | 105 ++++++++++
 tb/tb_window_buffer_kxk.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/window_buffer_pkg.sv
// rtl/window_buffer_pkg.sv - shared types and sizing helpers for the KxK window buffer
package window_buffer_pkg;

    typedef enum logic {
        FILL   = 1'b0,
        ACTIVE = 1'b1
    } wb_state_e;

    // Counter width that stays at least one bit for single-entry dimensions.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic bit params_legal(input int k, input int dw, input int cols, input int rows);
        return (k >= 2) && (k <= 15) && (dw >= 1) && (cols >= k) && (rows >= 1);
    endfunction

endpackage

// File: rtl/window_buffer_kxk_controller.sv
// rtl/window_buffer_kxk_controller.sv - column/row counters, fill state and window-valid tagging
// Optional macro: WINDOW_BUFFER_ZERO_PAD_EN (a window is emitted on every accept).
module window_buffer_kxk_controller
    import window_buffer_pkg::*;
#(
    parameter int K    = 7,
    parameter int COLS = 7,
    parameter int ROWS = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear_i,
    input  logic                    done_i,
`ifdef WINDOW_BUFFER_ZERO_PAD_EN
    output logic                    row_start_o,
`endif
    output logic [cnt_w(COLS)-1:0]  col_o,
    output logic [cnt_w(ROWS)-1:0]  row_o,
    output logic                    done_o,
    output logic                    progress_done_o
);

    localparam int CW = cnt_w(COLS);
    localparam int RW = cnt_w(ROWS);
    localparam logic [CW-1:0] COL_LAST      = CW'(COLS - 1);
    localparam logic [CW-1:0] COL_FILL_LAST = CW'(K - 2);
    localparam logic [RW-1:0] ROW_LAST      = RW'(ROWS - 1);

    wb_state_e       state_q, state_d, state_eff;
    logic [CW-1:0]   col_cnt_q, col_cnt_d, col_eff;
    logic [RW-1:0]   row_cnt_q, row_cnt_d, row_eff;
    logic [CW-1:0]   col_o_q, col_o_d;
    logic [RW-1:0]   row_o_q, row_o_d;
    logic            done_q, done_d;
    logic            progress_q, progress_d;

    // A clear is folded in before the accept so a simultaneous column becomes col 0 / row 0.
    always_comb begin
        col_eff    = clear_i ? '0 : col_cnt_q;
        row_eff    = clear_i ? '0 : row_cnt_q;
        state_eff  = clear_i ? FILL : state_q;
        col_cnt_d  = col_eff;
        row_cnt_d  = row_eff;
        state_d    = state_eff;
        col_o_d    = clear_i ? '0 : col_o_q;
        row_o_d    = clear_i ? '0 : row_o_q;
        done_d     = 1'b0;
        progress_d = 1'b0;

        if (done_i) begin
            col_o_d = col_eff;
            row_o_d = row_eff;
`ifdef WINDOW_BUFFER_ZERO_PAD_EN
            done_d  = 1'b1;
`else
            done_d  = (state_eff == ACTIVE);
`endif
            progress_d = done_d && (row_eff == ROW_LAST) && (col_eff == COL_LAST);

            if (col_eff == COL_LAST) begin
                col_cnt_d = '0;
                row_cnt_d = (row_eff == ROW_LAST) ? '0 : row_eff + RW'(1);
            end else begin
                col_cnt_d = col_eff + CW'(1);
            end

            case (state_eff)
                FILL:    if (col_eff == COL_FILL_LAST) state_d = ACTIVE;
                ACTIVE:  if (col_eff == COL_LAST)      state_d = FILL;
                default: state_d = FILL;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FILL;
            col_cnt_q  <= '0;
            row_cnt_q  <= '0;
            col_o_q    <= '0;
            row_o_q    <= '0;
            done_q     <= 1'b0;
            progress_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_cnt_q  <= col_cnt_d;
            row_cnt_q  <= row_cnt_d;
            col_o_q    <= col_o_d;
            row_o_q    <= row_o_d;
            done_q     <= done_d;
            progress_q <= progress_d;
        end
    end

`ifdef WINDOW_BUFFER_ZERO_PAD_EN
    assign row_start_o = done_i && (col_eff == '0);
`endif

    assign col_o           = col_o_q;
    assign row_o           = row_o_q;
    assign done_o          = done_q;
    assign progress_done_o = progress_q;

endmodule

// File: rtl/window_buffer_kxk.sv
// rtl/window_buffer_kxk.sv - KxK sliding-window shift array fed one pixel column per accept
// Optional macro: WINDOW_BUFFER_ZERO_PAD_EN (columns not yet filled in a row read as zero).
module window_buffer_kxk
    import window_buffer_pkg::*;
#(
    parameter int K    = 7,
    parameter int DW   = 8,
    parameter int COLS = 7,
    parameter int ROWS = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear_i,
    input  logic                    done_i,
    input  logic [K*DW-1:0]         col_i,
    output logic [K*K*DW-1:0]       window_o,
    output logic [cnt_w(COLS)-1:0]  col_o,
    output logic [cnt_w(ROWS)-1:0]  row_o,
    output logic                    done_o,
    output logic                    progress_done_o
);

    if (!params_legal(K, DW, COLS, ROWS)) begin : g_bad_params
        $error("window_buffer_kxk: illegal K/DW/COLS/ROWS combination");
    end

    logic [K*K*DW-1:0] window_q, window_d, window_base;

`ifdef WINDOW_BUFFER_ZERO_PAD_EN
    logic row_start;
`endif

    window_buffer_kxk_controller #(
        .K    (K),
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_ctrl (
        .clk             (clk),
        .rst             (rst),
        .clear_i         (clear_i),
        .done_i          (done_i),
`ifdef WINDOW_BUFFER_ZERO_PAD_EN
        .row_start_o     (row_start),
`endif
        .col_o           (col_o),
        .row_o           (row_o),
        .done_o          (done_o),
        .progress_done_o (progress_done_o)
    );

    // Column c takes column c+1; the newest column lands in K-1.
    always_comb begin
        window_base = clear_i ? '0 : window_q;
        window_d    = window_base;
        if (done_i) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) begin
                    window_d[(r*K+c)*DW +: DW] = window_base[(r*K+c+1)*DW +: DW];
                end
                window_d[(r*K+K-1)*DW +: DW] = col_i[r*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            window_q <= '0;
        end else begin
            window_q <= window_d;
        end
    end

`ifdef WINDOW_BUFFER_ZERO_PAD_EN
    logic [K-1:0] mask_q, mask_d, mask_base;

    // Mask bit c tracks whether window column c holds a pixel of the current row.
    always_comb begin
        mask_base = clear_i ? '0 : mask_q;
        mask_d    = mask_base;
        if (done_i) begin
            mask_d = row_start ? {1'b1, {(K-1){1'b0}}} : {1'b1, mask_base[K-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q <= '0;
        end else begin
            mask_q <= mask_d;
        end
    end

    always_comb begin
        window_o = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                window_o[(r*K+c)*DW +: DW] = mask_q[c] ? window_q[(r*K+c)*DW +: DW] : '0;
            end
        end
    end
`else
    assign window_o = window_q;
`endif

endmodule

// File: tb/tb_window_buffer_kxk.sv
// tb/tb_window_buffer_kxk.sv - directed self-checking bench for window_buffer_kxk (K=3, 5x2 frame)
module tb_window_buffer_kxk;

    localparam int K    = 3;
    localparam int DW   = 8;
    localparam int COLS = 5;
    localparam int ROWS = 2;
    localparam int WW   = K * K * DW;
`ifdef WINDOW_BUFFER_ZERO_PAD_EN
    localparam bit PAD  = 1'b1;
`else
    localparam bit PAD  = 1'b0;
`endif
    localparam int WINS_PER_FRAME = PAD ? ROWS * COLS : ROWS * (COLS - K + 1);

    logic            clk = 1'b0;
    logic            rst;
    logic            clear_i;
    logic            done_i;
    logic [K*DW-1:0] col_i;
    logic [WW-1:0]   window_o;
    logic [2:0]      col_o;
    logic [0:0]      row_o;
    logic            done_o;
    logic            progress_done_o;

    window_buffer_kxk #(
        .K    (K),
        .DW   (DW),
        .COLS (COLS),
        .ROWS (ROWS)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .clear_i         (clear_i),
        .done_i          (done_i),
        .col_i           (col_i),
        .window_o        (window_o),
        .col_o           (col_o),
        .row_o           (row_o),
        .done_o          (done_o),
        .progress_done_o (progress_done_o)
    );

    always #5 clk = ~clk;

    int              n_checks = 0;
    int              n_fail   = 0;
    int              dones;
    int              progs;
    int              ref_col;
    int              ref_row;
    logic [K*DW-1:0] ref_cols [COLS];
    logic [WW-1:0]   last_win;
    bit              last_done;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [K*DW-1:0] pix_col(input int c);
        logic [K*DW-1:0] v;
        for (int r = 0; r < K; r++) v[r*DW +: DW] = DW'(16 * r + c + 1);
        return v;
    endfunction

    task automatic accept(input logic [K*DW-1:0] v, input bit clr);
        logic [WW-1:0] ew;
        bit            ed;
        int            j;
        if (clr) begin
            ref_col = 0;
            ref_row = 0;
        end
        ref_cols[ref_col] = v;
        ed = PAD || (ref_col >= K - 1);
        ew = '0;
        for (int cc = 0; cc < K; cc++) begin
            j = ref_col - (K - 1) + cc;
            if (j >= 0)
                for (int r = 0; r < K; r++) ew[(r*K+cc)*DW +: DW] = ref_cols[j][r*DW +: DW];
        end
        done_i  = 1'b1;
        clear_i = clr;
        col_i   = v;
        @(posedge clk); #1;
        done_i  = 1'b0;
        clear_i = 1'b0;
        check("done_o", done_o, ed);
        if (ed) begin
            dones++;
            check("window_o", window_o, ew);
            check("col_o", col_o, ref_col);
            check("row_o", row_o, ref_row);
            check("progress_done_o", progress_done_o,
                  (ref_row == ROWS - 1) && (ref_col == COLS - 1));
        end else begin
            check("progress_idle", progress_done_o, 0);
        end
        if (progress_done_o) progs++;
        last_done = ed;
        last_win  = ew;
        if (ref_col == COLS - 1) begin
            ref_col = 0;
            ref_row = (ref_row == ROWS - 1) ? 0 : ref_row + 1;
        end else begin
            ref_col++;
        end
    endtask

    task automatic gap();
        done_i = 1'b0;
        @(posedge clk); #1;
        check("gap_done_o", done_o, 0);
        check("gap_progress", progress_done_o, 0);
        if (last_done) check("gap_window_hold", window_o, last_win);
    endtask

    task automatic outputs_zero(input string tag);
        check({tag, "_done"}, done_o, 0);
        check({tag, "_prog"}, progress_done_o, 0);
        check({tag, "_col"}, col_o, 0);
        check({tag, "_row"}, row_o, 0);
        check({tag, "_win"}, window_o, 0);
    endtask

    task automatic do_reset(input bit with_done);
        rst     = 1'b1;
        done_i  = with_done;
        col_i   = {K{8'h5A}};
        @(posedge clk); #1;
        rst     = 1'b0;
        done_i  = 1'b0;
        ref_col = 0;
        ref_row = 0;
        last_done = 1'b0;
        outputs_zero("reset");
    endtask

    // Hand-computed first windows of each row/frame, i is the accept index within a frame.
    task automatic hand_checks(input int i);
`ifdef WINDOW_BUFFER_ZERO_PAD_EN
        if (i == 0 || i == COLS) begin
            check("first_win_pad", window_o, 72'h210000_110000_010000);
            check("first_col_pad", col_o, 0);
            check("first_row_pad", row_o, i / COLS);
        end
`else
        if (i == 2) begin
            check("first_win", window_o, 72'h232221_131211_030201);
            check("first_col", col_o, 2);
            check("first_row", row_o, 0);
        end
`endif
    endtask

    task automatic run_frames(input int nframes, input bit gaps);
        dones = 0;
        progs = 0;
        for (int i = 0; i < nframes * ROWS * COLS; i++) begin
            accept(pix_col(i % COLS), 1'b0);
            hand_checks(i % (ROWS * COLS));
            if (gaps) gap();
        end
        check("window_count", dones, nframes * WINS_PER_FRAME);
        check("progress_count", progs, nframes);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b0;
        clear_i = 1'b0;
        done_i  = 1'b0;
        col_i   = '0;
        do_reset(1'b0);

        // Contiguous frame, then the same stream with a gap after every beat.
        run_frames(1, 1'b0);
        run_frames(1, 1'b1);

        // Clear together with a column mid-row 1.
        for (int i = 0; i < 7; i++) accept(pix_col(i % COLS), 1'b0);
        accept({K{8'hAA}}, 1'b1);
        check("clear_done_o", done_o, PAD);
        check("clear_col_o", col_o, 0);
        accept(pix_col(1), 1'b0);
        accept(pix_col(2), 1'b0);
        check("after_clear_win", window_o, 72'h2322AA_1312AA_0302AA);
        check("after_clear_col", col_o, 2);
        check("after_clear_row", row_o, 0);

        // Clear on its own.
        clear_i = 1'b1;
        @(posedge clk); #1;
        clear_i = 1'b0;
        ref_col = 0;
        ref_row = 0;
        last_done = 1'b0;
        outputs_zero("clear");

        // Reset mid-row 0 in the active phase, then a full restarted frame.
        for (int i = 0; i < 4; i++) accept(pix_col(i), 1'b0);
        do_reset(1'b1);
        run_frames(1, 1'b0);

        // Two frames back to back.
        run_frames(2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
